// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
    localparam int   PS2_DATA_BITS      = 8;
    localparam logic PS2_START_BIT      = 1'b0;
    localparam logic PS2_STOP_BIT       = 1'b1;
    localparam int   PS2_TIMEOUT_CYCLES = 10000;
endpackage

// File: rtl/ps2_sync2.sv
// ps2_sync2: two-flop synchroniser for a raw PS/2 line, resetting to the idle-high level.
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset (both flops go to 1)
//   d_i    - asynchronous input
//   q_o    - synchronised output
module ps2_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    assign q_o = sync_q;
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: assembles and checks 11-bit PS/2 device-to-host frames, presents bytes via ready/ack.
//   Clock        - system clock
//   nReset       - asynchronous active-low reset
//   FallingEdge  - one-cycle pulse per PS/2 clock falling edge
//   PS2Data      - raw PS/2 data line
//   DataAck      - consumer took DataByte (only meaningful while DataReady=1)
//   DataByte     - last good byte, held while DataReady=1
//   DataReady    - level, set on good frame, cleared by DataAck
//   ParityError  - pulse: bad parity frame discarded
//   FramingError - pulse: bad stop bit or inter-edge timeout
//   Overrun      - pulse: good frame dropped because DataReady was still set
//   Busy         - frame in progress
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       FallingEdge,
    input  logic       PS2Data,
    input  logic       DataAck,
    output logic [7:0] DataByte,
    output logic       DataReady,
    output logic       ParityError,
    output logic       FramingError,
    output logic       Overrun,
    output logic       Busy
);
    localparam int BW = $clog2(PS2_DATA_BITS);

    ps2_rx_state_t            state_q, state_d;
    logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d, byte_q, byte_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     par_q, par_d, rdy_q, rdy_d;
    logic                     perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q;
    logic                     data_s;

    ps2_sync2 u_sync (.clk_i(Clock), .rst_ni(nReset), .d_i(PS2Data), .q_o(data_s));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        par_d   = par_q;
        rdy_d   = rdy_q && !DataAck;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        // Inter-edge watchdog: only runs mid-frame, restarted by every edge.
        cnt_d   = (state_q == IDLE || FallingEdge) ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE:
                if (FallingEdge && data_s == PS2_START_BIT) begin
                    shreg_d = '0;
                    par_d   = 1'b0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            DATA:
                if (FallingEdge) begin
                    shreg_d = {data_s, shreg_q[PS2_DATA_BITS-1:1]};
                    par_d   = par_q ^ data_s;
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BW'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
                end
            PARITY:
                if (FallingEdge) begin
                    // Fold the parity bit in: a good frame leaves par_q = 1.
                    par_d   = par_q ^ data_s;
                    state_d = STOP;
                end
            STOP:
                if (FallingEdge) begin
                    state_d = IDLE;
                    if (data_s != PS2_STOP_BIT)
                        ferr_d = 1'b1;
                    else if (!par_q)
                        perr_d = 1'b1;
                    else if (!rdy_q || DataAck) begin
                        byte_d = shreg_q;
                        rdy_d  = 1'b1;
                    end else
                        ovr_d = 1'b1;
                end
        endcase
        if (state_q != IDLE && !FallingEdge && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clock or negedge nReset)
        if (!nReset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != IDLE);
        end

    assign DataByte     = byte_q;
    assign DataReady    = rdy_q;
    assign ParityError  = perr_q;
    assign FramingError = ferr_q;
    assign Overrun      = ovr_q;
    assign Busy         = busy_q;
endmodule
